ctrl_result_writeback: RTL and testbench

- Write-side counterpart of the data-setup path: consumes skewed partial-sum lanes from the systolic array, de-skews them, requantizes each lane to DATA_BW, and packs each output vector into one WORDSIZE word.
- Writes each word into the SRAM unified buffer at consecutive addresses from a programmed base.
- Sits between the systolic array result bus and the UB write port (sram_write_enable / sram_address / sram_data_in).
- Start/busy/done handshake toward the top-level controller.

---
 rtl/ctrl_result_writeback_if.sv | 35 +++
 rtl/ctrl_result_writeback.sv | 178 +++++++++++++++++
 tb/tb_ctrl_result_writeback.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ctrl_result_writeback_if.sv
// rtl/ctrl_result_writeback_if.sv - controller, result-bus and UB write-port bundle for ctrl_result_writeback
interface ctrl_result_writeback_if #(
  parameter int ADDRESSSIZE    = 10,
  parameter int WORDSIZE       = 64,
  parameter int NUM_PE_ROWS    = 8,
  parameter int PARTIAL_SUM_BW = 19
);
  // job control from the top-level controller
  logic                                  start;
  logic [ADDRESSSIZE-1:0]                base_addr;
  logic [ADDRESSSIZE-1:0]                num_vectors;
  logic                                  busy;
  logic                                  done;

  // skewed result lanes from the systolic array
  logic                                  result_valid;
  logic [PARTIAL_SUM_BW*NUM_PE_ROWS-1:0] result;

  // unified buffer write port
  logic                                  sram_write_enable;
  logic [ADDRESSSIZE-1:0]                sram_address;
  logic [WORDSIZE-1:0]                   sram_data_in;

  // environment side: controller plus array driving the writeback block
  modport master (
    output start, base_addr, num_vectors, result_valid, result,
    input  busy, done, sram_write_enable, sram_address, sram_data_in
  );

  // writeback block side
  modport slave (
    input  start, base_addr, num_vectors, result_valid, result,
    output busy, done, sram_write_enable, sram_address, sram_data_in
  );
endinterface

// File: rtl/ctrl_result_writeback.sv
// rtl/ctrl_result_writeback.sv - de-skew, requantize and pack systolic results into UB writes (optional WB_RELU_EN)
module ctrl_result_writeback #(
  parameter int ADDRESSSIZE    = 10,
  parameter int WORDSIZE       = 64,
  parameter int NUM_PE_ROWS    = 8,
  parameter int PARTIAL_SUM_BW = 19,
  parameter int DATA_BW        = 8,
  parameter int OUT_SHIFT      = 0
) (
  input logic                    clk,
  input logic                    rstn,
  ctrl_result_writeback_if.slave bus
);

  localparam int PSB = PARTIAL_SUM_BW;

  // Saturation bounds expressed at lane width so the comparison stays signed.
  localparam logic signed [PSB-1:0] SAT_MAX = PSB'((1 << (DATA_BW - 1)) - 1);
  localparam logic signed [PSB-1:0] SAT_MIN = PSB'(-(1 << (DATA_BW - 1)));

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [PSB*NUM_PE_ROWS-1:0] aligned_flat;
  logic [NUM_PE_ROWS-2:0]     valid_pipe;
  logic                       aligned_valid;
  logic [WORDSIZE-1:0]        packed_word;
  logic signed [PSB-1:0]      lane_val;
  logic signed [PSB-1:0]      lane_shifted;

  logic [ADDRESSSIZE-1:0]     addr_q;
  logic [ADDRESSSIZE-1:0]     remaining_q;
  logic                       we_q;
  logic [ADDRESSSIZE-1:0]     wr_addr_q;
  logic [WORDSIZE-1:0]        wr_data_q;
  logic                       write_now;

  // ---------------------------------------------------------------------------
  // De-skew: lane i arrives i cycles after lane 0, so it is held back by
  // NUM_PE_ROWS-1-i stages; the last lane is already aligned and passes through.
  // ---------------------------------------------------------------------------
  for (genvar i = 0; i < NUM_PE_ROWS; i++) begin : g_lane
    localparam int DEPTH = NUM_PE_ROWS - 1 - i;

    if (DEPTH == 0) begin : g_pass
      assign aligned_flat[i*PSB +: PSB] = bus.result[i*PSB +: PSB];
    end else begin : g_dly
      logic [DEPTH-1:0][PSB-1:0] dly;

      // Shift the lane through its delay line; runs regardless of FSM state.
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          dly <= '0;
        end else begin
          dly[0] <= bus.result[i*PSB +: PSB];
          for (int k = 1; k < DEPTH; k++) begin
            dly[k] <= dly[k-1];
          end
        end
      end

      assign aligned_flat[i*PSB +: PSB] = dly[DEPTH-1];
    end
  end

  // Delay lane-0 valid by NUM_PE_ROWS-1 stages so it lines up with the last lane.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_pipe <= '0;
    end else begin
      valid_pipe[0] <= bus.result_valid;
      for (int k = 1; k < NUM_PE_ROWS - 1; k++) begin
        valid_pipe[k] <= valid_pipe[k-1];
      end
    end
  end

  assign aligned_valid = valid_pipe[NUM_PE_ROWS-2];

  // Requantize every aligned lane: arithmetic shift, optional ReLU, saturate, pack.
  always_comb begin
    packed_word  = '0;
    lane_val     = '0;
    lane_shifted = '0;
    for (int i = 0; i < NUM_PE_ROWS; i++) begin
      lane_val     = aligned_flat[i*PSB +: PSB];
      lane_shifted = lane_val >>> OUT_SHIFT;
`ifdef WB_RELU_EN
      if (lane_shifted[PSB-1]) begin
        lane_shifted = '0;
      end
`endif
      if (lane_shifted > SAT_MAX) begin
        packed_word[i*DATA_BW +: DATA_BW] = SAT_MAX[DATA_BW-1:0];
      end else if (lane_shifted < SAT_MIN) begin
        packed_word[i*DATA_BW +: DATA_BW] = SAT_MIN[DATA_BW-1:0];
      end else begin
        packed_word[i*DATA_BW +: DATA_BW] = lane_shifted[DATA_BW-1:0];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Job control
  // ---------------------------------------------------------------------------

  // A write happens only while a job is running; aligned vectors otherwise drop.
  assign write_now = (state_q == ST_RUN) && aligned_valid;

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: start is honoured only from IDLE; the last counted write ends the job.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = (bus.num_vectors == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (write_now && (remaining_q == ADDRESSSIZE'(1))) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Job counters plus the registered UB write port; address wraps naturally.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      addr_q      <= '0;
      remaining_q <= '0;
      we_q        <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
    end else begin
      we_q <= 1'b0;
      if ((state_q == ST_IDLE) && bus.start) begin
        addr_q      <= bus.base_addr;
        remaining_q <= bus.num_vectors;
      end
      if (write_now) begin
        we_q        <= 1'b1;
        wr_addr_q   <= addr_q;
        wr_data_q   <= packed_word;
        addr_q      <= addr_q + ADDRESSSIZE'(1);
        remaining_q <= remaining_q - ADDRESSSIZE'(1);
      end
    end
  end

  assign bus.sram_write_enable = we_q;
  assign bus.sram_address      = wr_addr_q;
  assign bus.sram_data_in      = wr_data_q;
  assign bus.busy              = (state_q == ST_RUN);
  assign bus.done              = (state_q == ST_DONE);

endmodule

// File: tb/tb_ctrl_result_writeback.sv
// tb/tb_ctrl_result_writeback.sv - self-checking bench for ctrl_result_writeback
module tb_ctrl_result_writeback;
  localparam int A   = 10;
  localparam int W   = 64;
  localparam int N   = 8;
  localparam int PSB = 19;
  localparam int DB  = 8;
  localparam int SLOTS = 4096;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  ctrl_result_writeback_if #(.ADDRESSSIZE(A), .WORDSIZE(W), .NUM_PE_ROWS(N), .PARTIAL_SUM_BW(PSB)) bus0 ();
  ctrl_result_writeback_if #(.ADDRESSSIZE(A), .WORDSIZE(W), .NUM_PE_ROWS(N), .PARTIAL_SUM_BW(PSB)) bus2 ();

  ctrl_result_writeback #(.ADDRESSSIZE(A), .WORDSIZE(W), .NUM_PE_ROWS(N), .PARTIAL_SUM_BW(PSB),
                          .DATA_BW(DB), .OUT_SHIFT(0)) u0 (.clk(clk), .rstn(rstn), .bus(bus0));
  ctrl_result_writeback #(.ADDRESSSIZE(A), .WORDSIZE(W), .NUM_PE_ROWS(N), .PARTIAL_SUM_BW(PSB),
                          .DATA_BW(DB), .OUT_SHIFT(2)) u2 (.clk(clk), .rstn(rstn), .bus(bus2));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // vectors to present; lane values as plain integers
  int vbuf [16][N];
  int lane0_k = 0;

  // expected byte stream computed from the arithmetic rules
  function automatic logic [63:0] pack_word(input int k, input int sh);
    logic [63:0] w;
    int x;
    w = '0;
    for (int i = 0; i < N; i++) begin
      x = vbuf[k][i] >>> sh;
`ifdef WB_RELU_EN
      if (x < 0) x = 0;
`endif
      if (x > 127) x = 127;
      if (x < -128) x = -128;
      w[i*8 +: 8] = x[7:0];
    end
    return w;
  endfunction

  // ---------------------------------------------------------------- model
  int          ecount = 0;
  bit          sv  [SLOTS];
  logic [63:0] sw0 [SLOTS];
  logic [63:0] sw2 [SLOTS];
  bit          job_open = 0;
  bit          done_now = 0;
  int          writes_left = 0;
  int          next_addr = 0;
  int          slot;
  bit          fire;
  int          l0_edge = -1;
  int          start_edge = -1;
  bit          exp_we = 0, exp_busy = 0, exp_done = 0;
  logic [63:0] exp_addr = '0, exp_d0 = '0, exp_d2 = '0;

  always @(posedge clk) begin
    ecount = ecount + 1;
    if (!rstn) begin
      for (int j = 0; j < SLOTS; j++) sv[j] = 0;
      job_open = 0; done_now = 0; exp_we = 0; exp_busy = 0; exp_done = 0;
    end else begin
      slot = ecount % SLOTS;
      fire = sv[slot];
      sv[slot] = 0;
      if (bus0.result_valid) begin
        l0_edge = ecount;
        sv [(ecount + N - 1) % SLOTS] = 1;
        sw0[(ecount + N - 1) % SLOTS] = pack_word(lane0_k, 0);
        sw2[(ecount + N - 1) % SLOTS] = pack_word(lane0_k, 2);
      end
      exp_we = 0;
      if (done_now) begin
        done_now = 0;
      end else if (job_open) begin
        if (fire) begin
          exp_we = 1; exp_addr = 64'(next_addr); exp_d0 = sw0[slot]; exp_d2 = sw2[slot];
          next_addr = (next_addr + 1) % 1024;
          writes_left--;
          if (writes_left == 0) begin job_open = 0; done_now = 1; end
        end
      end else if (bus0.start) begin
        start_edge = ecount;
        if (bus0.num_vectors == 0) done_now = 1;
        else begin job_open = 1; next_addr = int'(bus0.base_addr); writes_left = int'(bus0.num_vectors); end
      end
      exp_busy = job_open;
      exp_done = done_now;
    end
  end

  // ---------------------------------------------------------------- compare
  int          wlog_addr[$];
  logic [63:0] wlog_d0[$];
  logic [63:0] wlog_d2[$];
  int          wlog_edge[$];
  int          done_edge = -1;

  always @(negedge clk) begin
    check("we0",   64'(bus0.sram_write_enable), 64'(exp_we));
    check("we2",   64'(bus2.sram_write_enable), 64'(exp_we));
    check("busy0", 64'(bus0.busy), 64'(exp_busy));
    check("busy2", 64'(bus2.busy), 64'(exp_busy));
    check("done0", 64'(bus0.done), 64'(exp_done));
    check("done2", 64'(bus2.done), 64'(exp_done));
    if (exp_we) begin
      check("addr0", 64'(bus0.sram_address), exp_addr);
      check("addr2", 64'(bus2.sram_address), exp_addr);
      check("data0", bus0.sram_data_in, exp_d0);
      check("data2", bus2.sram_data_in, exp_d2);
    end
    if (bus0.sram_write_enable) begin
      wlog_addr.push_back(int'(bus0.sram_address));
      wlog_d0.push_back(bus0.sram_data_in);
      wlog_d2.push_back(bus2.sram_data_in);
      wlog_edge.push_back(ecount);
    end
    if (bus0.done) done_edge = ecount;
  end

  // ---------------------------------------------------------------- stimulus
  task automatic set_job(input bit s, input int base, input int num);
    bus0.start = s; bus2.start = s;
    bus0.base_addr = A'(base); bus2.base_addr = A'(base);
    bus0.num_vectors = A'(num); bus2.num_vectors = A'(num);
  endtask

  task automatic job(input int base, input int num);
    @(negedge clk); set_job(1'b1, base, num);
    @(negedge clk); set_job(1'b0, 0, 0);
  endtask

  task automatic present(input int nv);
    logic [PSB*N-1:0] res;
    int k, v;
    for (int t = 0; t < nv + N - 1; t++) begin
      @(negedge clk);
      res = '0;
      for (int i = 0; i < N; i++) begin
        k = t - i;
        v = (k >= 0 && k < nv) ? vbuf[k][i] : 0;
        res[i*PSB +: PSB] = v[PSB-1:0];
      end
      lane0_k = t;
      bus0.result = res; bus2.result = res;
      bus0.result_valid = (t < nv); bus2.result_valid = (t < nv);
    end
    @(negedge clk);
    bus0.result = '0; bus2.result = '0;
    bus0.result_valid = 1'b0; bus2.result_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_logs();
    wlog_addr.delete(); wlog_d0.delete(); wlog_d2.delete(); wlog_edge.delete();
    done_edge = -1;
  endtask

  logic [63:0] lit_sat0, lit_sat2, lit_sh2;
  bit seen;

  initial begin
    set_job(1'b0, 0, 0);
    bus0.result_valid = 1'b0; bus2.result_valid = 1'b0;
    bus0.result = '0; bus2.result = '0;
    idle(3);
    check("rst_we",   64'(bus0.sram_write_enable), 64'd0);
    check("rst_addr", 64'(bus0.sram_address), 64'd0);
    check("rst_data", bus0.sram_data_in, 64'd0);
    check("rst_busy", 64'(bus0.busy), 64'd0);
    check("rst_done", 64'(bus0.done), 64'd0);
    #2 rstn = 1'b1;
    idle(2);

    // basic: lanes i = i
    for (int i = 0; i < N; i++) vbuf[0][i] = i;
    check("pin_basic", pack_word(0, 0), 64'h0706050403020100);
    clear_logs();
    job(12'h010, 1);
    present(1);
    idle(6);
    check("basic_n", 64'(wlog_addr.size()), 64'd1);
    if (wlog_addr.size() == 1) begin
      check("basic_addr", 64'(wlog_addr[0]), 64'h010);
      check("basic_data", wlog_d0[0], 64'h0706050403020100);
      check("basic_lat",  64'(wlog_edge[0] - l0_edge), 64'(N - 1));
      check("basic_done", 64'(done_edge), 64'(wlog_edge[0]));
    end

    // saturation
    vbuf[0][0] = 300; vbuf[0][1] = -300;
    for (int i = 2; i < N; i++) vbuf[0][i] = 5;
`ifdef WB_RELU_EN
    lit_sat0 = 64'h050505050505007F; lit_sat2 = 64'h010101010101004B;
`else
    lit_sat0 = 64'h050505050505807F; lit_sat2 = 64'h010101010101B54B;
`endif
    check("pin_sat", pack_word(0, 0), lit_sat0);
    clear_logs();
    job(12'h020, 1);
    present(1);
    idle(6);
    check("sat_n", 64'(wlog_addr.size()), 64'd1);
    if (wlog_addr.size() == 1) begin
      check("sat_data0", wlog_d0[0], lit_sat0);
      check("sat_data2", wlog_d2[0], lit_sat2);
    end

    // shift by 2 on the second instance
    for (int i = 0; i < N; i++) vbuf[0][i] = 0;
    vbuf[0][0] = -9; vbuf[0][1] = 1000;
`ifdef WB_RELU_EN
    lit_sh2 = 64'h0000000000007F00;
`else
    lit_sh2 = 64'h0000000000007FFD;
`endif
    check("pin_shift", pack_word(0, 2), lit_sh2);
    clear_logs();
    job(12'h030, 1);
    present(1);
    idle(6);
    check("shift_n", 64'(wlog_addr.size()), 64'd1);
    if (wlog_addr.size() == 1) check("shift_data2", wlog_d2[0], lit_sh2);

    // streaming with wrap and a dropped 4th vector
    for (int k = 0; k < 4; k++)
      for (int i = 0; i < N; i++) vbuf[k][i] = k * 16 + i - 20;
    clear_logs();
    job(12'h3FF, 3);
    present(4);
    idle(6);
    check("wrap_n", 64'(wlog_addr.size()), 64'd3);
    if (wlog_addr.size() == 3) begin
      check("wrap_a0", 64'(wlog_addr[0]), 64'h3FF);
      check("wrap_a1", 64'(wlog_addr[1]), 64'h000);
      check("wrap_a2", 64'(wlog_addr[2]), 64'h001);
      check("wrap_b2b", 64'(wlog_edge[2] - wlog_edge[0]), 64'd2);
      check("wrap_done", 64'(done_edge), 64'(wlog_edge[2]));
    end

    // zero-length job, then a vector with no job open
    clear_logs();
    job(12'h040, 0);
    idle(2);
    check("zero_done", 64'(done_edge), 64'(start_edge));
    present(1);
    idle(6);
    check("zero_n", 64'(wlog_addr.size()), 64'd0);

    // start while running is ignored
    clear_logs();
    job(12'h100, 2);
    present(1);
    job(12'h200, 5);
    present(1);
    idle(6);
    check("ign_n", 64'(wlog_addr.size()), 64'd2);
    if (wlog_addr.size() == 2) begin
      check("ign_a0", 64'(wlog_addr[0]), 64'h100);
      check("ign_a1", 64'(wlog_addr[1]), 64'h101);
    end
    check("ign_busy", 64'(bus0.busy), 64'd0);

    // reset mid-job
    clear_logs();
    job(12'h180, 4);
    fork
      present(4);
      begin
        seen = 0;
        for (int c = 0; c < 40 && !seen; c++) begin
          @(negedge clk);
          if (bus0.sram_write_enable) seen = 1;
        end
        check("rstmid_wait", 64'(seen), 64'd1);
        #2 rstn = 1'b0;
        #1;
        check("rstmid_we",   64'(bus0.sram_write_enable), 64'd0);
        check("rstmid_addr", 64'(bus0.sram_address), 64'd0);
        check("rstmid_data", bus0.sram_data_in, 64'd0);
        check("rstmid_busy", 64'(bus0.busy), 64'd0);
        check("rstmid_we2",  64'(bus2.sram_write_enable), 64'd0);
        idle(3);
        #2 rstn = 1'b1;
      end
    join
    idle(20);
    check("rstmid_n", 64'(wlog_addr.size()), 64'd1);
    for (int i = 0; i < N; i++) vbuf[0][i] = 2 * i;
    job(12'h050, 1);
    present(1);
    idle(6);
    check("post_n", 64'(wlog_addr.size()), 64'd2);
    if (wlog_addr.size() == 2) begin
      check("post_addr", 64'(wlog_addr[1]), 64'h050);
      check("post_data", wlog_d0[1], 64'h0E0C0A0806040200);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
